// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side connection bundle for the hazard controller.
//   in_IDRs_5 / in_IDRt_5      : source fields of the instruction in ID
//   in_IDUsesRs / in_IDUsesRt  : ID instruction actually reads rs / rt
//   in_IDRegWrite, in_IDDest_5 : ID instruction writes a register, and which one
//   in_EXJump                  : jump/jal/jr in EX, redirect at the next edge
//   in_MEMBranchTaken          : taken branch in MEM, redirect at the next edge
//   o_PCEnable / o_IFIDEnable  : pipeline front-end load enables
//   o_IFIDFlush / o_IDEXFlush / o_EXMEMFlush : pipeline register zeroing
//   o_State_2                  : action taken at the previous edge (0 RUN, 1 STALL, 2 FLUSH)
//   o_StallCount / o_FlushCount: saturating debug event counters
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_controller_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [4:0]           in_IDRs_5;
  logic [4:0]           in_IDRt_5;
  logic                 in_IDUsesRs;
  logic                 in_IDUsesRt;
  logic                 in_IDRegWrite;
  logic [4:0]           in_IDDest_5;
  logic                 in_EXJump;
  logic                 in_MEMBranchTaken;
  logic                 o_PCEnable;
  logic                 o_IFIDEnable;
  logic                 o_IFIDFlush;
  logic                 o_IDEXFlush;
  logic                 o_EXMEMFlush;
  logic [1:0]           o_State_2;
  logic [CNT_WIDTH-1:0] o_StallCount;
  logic [CNT_WIDTH-1:0] o_FlushCount;

  modport master (
    output in_IDRs_5, in_IDRt_5, in_IDUsesRs, in_IDUsesRt,
           in_IDRegWrite, in_IDDest_5, in_EXJump, in_MEMBranchTaken,
    input  o_PCEnable, o_IFIDEnable, o_IFIDFlush, o_IDEXFlush,
           o_EXMEMFlush, o_State_2, o_StallCount, o_FlushCount
  );

  modport slave (
    input  in_IDRs_5, in_IDRt_5, in_IDUsesRs, in_IDUsesRt,
           in_IDRegWrite, in_IDDest_5, in_EXJump, in_MEMBranchTaken,
    output o_PCEnable, o_IFIDEnable, o_IFIDFlush, o_IDEXFlush,
           o_EXMEMFlush, o_State_2, o_StallCount, o_FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Interlock and flush sequencer for a 5-stage MIPS pipeline without forwarding.
// A 3-entry scoreboard (EX, MEM, WB) tracks in-flight destination registers;
// RAW hazards stall PC and IF/ID and inject an ID/EX bubble, while jumps (EX)
// and taken branches (MEM) flush the wrong-path instructions.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset, released synchronously by the next edge
//   io_bus : slave side of pipeline_hazard_controller_if (ID fields, redirects,
//            enables/flushes, last action, debug counters)
// Parameters:
//   WB_BYPASS : 1 = register file writes before reads, WB entry never hazards
//   CNT_WIDTH : width of the saturating stall/flush counters
module pipeline_hazard_controller #(
  parameter bit          WB_BYPASS = 1'b0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic                        clk,
  input logic                        reset,
  pipeline_hazard_controller_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } action_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  sb_entry_t            r_sb_ex;
  sb_entry_t            r_sb_mem;
  sb_entry_t            r_sb_wb;
  action_e              r_state;
  action_e              w_action;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_hot_ex;
  logic w_hot_mem;
  logic w_hot_wb;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_hazard;

  // $0 is hard-wired, so entries targeting it never block anything.
  assign w_hot_ex  = r_sb_ex.valid  && (r_sb_ex.dest  != 5'd0);
  assign w_hot_mem = r_sb_mem.valid && (r_sb_mem.dest != 5'd0);
  assign w_hot_wb  = !WB_BYPASS && r_sb_wb.valid && (r_sb_wb.dest != 5'd0);

  assign w_rs_hit = io_bus.in_IDUsesRs && (io_bus.in_IDRs_5 != 5'd0) &&
                    ((w_hot_ex  && (r_sb_ex.dest  == io_bus.in_IDRs_5)) ||
                     (w_hot_mem && (r_sb_mem.dest == io_bus.in_IDRs_5)) ||
                     (w_hot_wb  && (r_sb_wb.dest  == io_bus.in_IDRs_5)));

  assign w_rt_hit = io_bus.in_IDUsesRt && (io_bus.in_IDRt_5 != 5'd0) &&
                    ((w_hot_ex  && (r_sb_ex.dest  == io_bus.in_IDRt_5)) ||
                     (w_hot_mem && (r_sb_mem.dest == io_bus.in_IDRt_5)) ||
                     (w_hot_wb  && (r_sb_wb.dest  == io_bus.in_IDRt_5)));

  assign w_hazard = w_rs_hit || w_rt_hit;

  // Redirects outrank the stall: a stalled ID instruction behind a redirect
  // is on the wrong path anyway.
  always_comb begin
    w_action            = ST_RUN;
    io_bus.o_PCEnable   = 1'b1;
    io_bus.o_IFIDEnable = 1'b1;
    io_bus.o_IFIDFlush  = 1'b0;
    io_bus.o_IDEXFlush  = 1'b0;
    io_bus.o_EXMEMFlush = 1'b0;
    if (io_bus.in_MEMBranchTaken) begin
      w_action            = ST_FLUSH;
      io_bus.o_IFIDFlush  = 1'b1;
      io_bus.o_IDEXFlush  = 1'b1;
      io_bus.o_EXMEMFlush = 1'b1;
    end else if (io_bus.in_EXJump) begin
      w_action           = ST_FLUSH;
      io_bus.o_IFIDFlush = 1'b1;
      io_bus.o_IDEXFlush = 1'b1;
    end else if (w_hazard) begin
      w_action            = ST_STALL;
      io_bus.o_PCEnable   = 1'b0;
      io_bus.o_IFIDEnable = 1'b0;
      io_bus.o_IDEXFlush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb_ex     <= '0;
      r_sb_mem    <= '0;
      r_sb_wb     <= '0;
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_sb_wb  <= r_sb_mem;
      // Taken branch kills the instruction moving from EX into MEM.
      r_sb_mem <= io_bus.in_MEMBranchTaken ? sb_entry_t'('0) : r_sb_ex;
      // Only an issuing ID instruction enters EX; stalls and flushes insert a bubble.
      r_sb_ex  <= (w_action == ST_RUN) ?
                  sb_entry_t'({io_bus.in_IDRegWrite, io_bus.in_IDDest_5}) :
                  sb_entry_t'('0);
      r_state  <= w_action;
      if ((w_action == ST_STALL) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if ((w_action == ST_FLUSH) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign io_bus.o_State_2    = r_state;
  assign io_bus.o_StallCount = r_stall_cnt;
  assign io_bus.o_FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: three controllers (no bypass, WB bypass, narrow counters)
// share one stimulus stream; a vector table drives per-cycle control checks
// through an expectation queue, hand sequences cover counters and reset.
module tb_pipeline_hazard_controller;

  logic clk;
  logic reset;

  pipeline_hazard_controller_if #(.CNT_WIDTH(16)) m0 ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(16)) m1 ();
  pipeline_hazard_controller_if #(.CNT_WIDTH(2))  m2 ();

  pipeline_hazard_controller #(.WB_BYPASS(1'b0), .CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .reset(reset), .io_bus(m0.slave));
  pipeline_hazard_controller #(.WB_BYPASS(1'b1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .io_bus(m1.slave));
  pipeline_hazard_controller #(.WB_BYPASS(1'b0), .CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .io_bus(m2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCEnable, IFIDEnable, IFIDFlush, IDEXFlush, EXMEMFlush}
  localparam logic [4:0] C_RUN = 5'b11000;
  localparam logic [4:0] C_STL = 5'b00010;
  localparam logic [4:0] C_JMP = 5'b11110;
  localparam logic [4:0] C_BR  = 5'b11111;

  logic [4:0] c0, c1, c2;
  assign c0 = {m0.o_PCEnable, m0.o_IFIDEnable, m0.o_IFIDFlush, m0.o_IDEXFlush, m0.o_EXMEMFlush};
  assign c1 = {m1.o_PCEnable, m1.o_IFIDEnable, m1.o_IFIDFlush, m1.o_IDEXFlush, m1.o_EXMEMFlush};
  assign c2 = {m2.o_PCEnable, m2.o_IFIDEnable, m2.o_IFIDFlush, m2.o_IDEXFlush, m2.o_EXMEMFlush};

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       ur, ut, rw;
    logic [4:0] dest;
    logic       jmp, br;
    logic [4:0] e0, e1;
  } vec_t;

  typedef struct {
    int         idx;
    logic [4:0] c0, c1;
    logic [1:0] s0, s1;
  } exp_t;

  localparam int NV = 28;
  vec_t vecs[NV];
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic ut, input logic rw,
                              input logic [4:0] dest, input logic jmp, input logic br,
                              input logic [4:0] e0, input logic [4:0] e1);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.ur = ur; v.ut = ut; v.rw = rw;
    v.dest = dest; v.jmp = jmp; v.br = br; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic logic [1:0] act_of(input logic [4:0] c);
    if (c == C_STL) return 2'd1;
    if (c[2])       return 2'd2;
    return 2'd0;
  endfunction

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic ut, input logic rw, input logic [4:0] dest,
                     input logic jmp, input logic br);
    m0.in_IDRs_5 = rs; m0.in_IDRt_5 = rt; m0.in_IDUsesRs = ur; m0.in_IDUsesRt = ut;
    m0.in_IDRegWrite = rw; m0.in_IDDest_5 = dest; m0.in_EXJump = jmp; m0.in_MEMBranchTaken = br;
    m1.in_IDRs_5 = rs; m1.in_IDRt_5 = rt; m1.in_IDUsesRs = ur; m1.in_IDUsesRt = ut;
    m1.in_IDRegWrite = rw; m1.in_IDDest_5 = dest; m1.in_EXJump = jmp; m1.in_MEMBranchTaken = br;
    m2.in_IDRs_5 = rs; m2.in_IDRt_5 = rt; m2.in_IDUsesRs = ur; m2.in_IDUsesRt = ut;
    m2.in_IDRegWrite = rw; m2.in_IDDest_5 = dest; m2.in_EXJump = jmp; m2.in_MEMBranchTaken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    logic [1:0] prev0, prev1;

    //            rst rs    rt    ur ut rw dest  jmp br  dut0   dut1
    vecs[0]  = mk(1, 5'd2, 5'd3, 1, 1, 1, 5'd1, 0, 0, C_RUN, C_RUN);  // add $1,$2,$3
    vecs[1]  = mk(0, 5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 0, C_STL, C_STL);  // sub $4,$1,$5
    vecs[2]  = mk(0, 5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 0, C_STL, C_STL);
    vecs[3]  = mk(0, 5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 0, C_STL, C_RUN);
    vecs[4]  = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_RUN, C_RUN);
    vecs[5]  = mk(1, 5'd0, 5'd8, 1, 0, 1, 5'd8, 0, 0, C_RUN, C_RUN);  // lw $8,0($0)
    vecs[6]  = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_RUN, C_RUN);  // nop
    vecs[7]  = mk(0, 5'd8, 5'd8, 1, 1, 1, 5'd9, 0, 0, C_STL, C_STL);  // add $9,$8,$8
    vecs[8]  = mk(0, 5'd8, 5'd8, 1, 1, 1, 5'd9, 0, 0, C_STL, C_RUN);
    vecs[9]  = mk(0, 5'd8, 5'd8, 1, 1, 1, 5'd9, 0, 0, C_RUN, C_RUN);
    vecs[10] = mk(0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, C_RUN, C_RUN);  // addi $0,$0,5
    vecs[11] = mk(0, 5'd0, 5'd0, 1, 1, 1, 5'd3, 0, 0, C_RUN, C_RUN);  // add $3,$0,$0
    vecs[12] = mk(1, 5'd2, 5'd3, 1, 1, 1, 5'd1, 0, 0, C_RUN, C_RUN);
    vecs[13] = mk(0, 5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 1, C_BR,  C_BR);   // branch over hazard
    vecs[14] = mk(0, 5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 0, C_RUN, C_RUN);
    vecs[15] = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_RUN, C_RUN);
    vecs[16] = mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd31, 0, 0, C_RUN, C_RUN); // jal
    vecs[17] = mk(0, 5'd31, 5'd0, 1, 0, 1, 5'd5, 1, 0, C_JMP, C_JMP); // jal in EX
    vecs[18] = mk(0, 5'd31, 5'd0, 1, 1, 1, 5'd2, 0, 0, C_STL, C_STL); // add $2,$31,$0
    vecs[19] = mk(0, 5'd31, 5'd0, 1, 1, 1, 5'd2, 0, 0, C_STL, C_RUN);
    vecs[20] = mk(0, 5'd31, 5'd0, 1, 1, 1, 5'd2, 0, 0, C_RUN, C_RUN);
    vecs[21] = mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0, C_RUN, C_RUN);
    vecs[22] = mk(0, 5'd7, 5'd0, 0, 1, 0, 5'd0, 0, 0, C_RUN, C_RUN);  // rs matches but unused
    vecs[23] = mk(0, 5'd0, 5'd7, 1, 1, 0, 5'd0, 0, 0, C_STL, C_STL);  // rt-only hazard
    vecs[24] = mk(0, 5'd0, 5'd7, 1, 1, 0, 5'd0, 0, 0, C_STL, C_RUN);
    vecs[25] = mk(0, 5'd0, 5'd7, 1, 1, 0, 5'd0, 0, 0, C_RUN, C_RUN);
    vecs[26] = mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, C_BR,  C_BR);   // branch beats jump
    vecs[27] = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_RUN, C_RUN);

    // Reset state, checked while reset is held low.
    reset = 1'b0;
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #12;
    chk("rst ctrl0", 32'(c0), 32'(C_RUN));
    chk("rst state0", 32'(m0.o_State_2), 32'd0);
    chk("rst stall0", 32'(m0.o_StallCount), 32'd0);
    chk("rst flush0", 32'(m0.o_FlushCount), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    prev0 = 2'd0;
    prev1 = 2'd0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) begin
        reset_all();
        prev0 = 2'd0;
        prev1 = 2'd0;
      end
      tick();
      drv(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].ut, vecs[i].rw,
          vecs[i].dest, vecs[i].jmp, vecs[i].br);
      e.idx = i; e.c0 = vecs[i].e0; e.c1 = vecs[i].e1; e.s0 = prev0; e.s1 = prev1;
      sbq.push_back(e);
      prev0 = act_of(vecs[i].e0);
      prev1 = act_of(vecs[i].e1);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("row%0d ctrl0", e.idx), 32'(c0), 32'(e.c0));
      chk($sformatf("row%0d ctrl1", e.idx), 32'(c1), 32'(e.c1));
      chk($sformatf("row%0d ctrl2", e.idx), 32'(c2), 32'(e.c0));
      chk($sformatf("row%0d state0", e.idx), 32'(m0.o_State_2), 32'(e.s0));
      chk($sformatf("row%0d state1", e.idx), 32'(m1.o_State_2), 32'(e.s1));
    end

    // Stall counting, saturation, and reset during a stall.
    reset_all();
    tick();
    drv(5'd2, 5'd3, 1, 1, 1, 5'd1, 0, 0);      // add $1
    tick();
    drv(5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 0);      // sub $4,$1,$5
    tick(); tick(); tick();
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    tick();
    chk("stallcnt0 raw", 32'(m0.o_StallCount), 32'd3);
    chk("stallcnt1 raw", 32'(m1.o_StallCount), 32'd2);
    chk("stallcnt2 raw", 32'(m2.o_StallCount), 32'd3);
    chk("flushcnt0 raw", 32'(m0.o_FlushCount), 32'd0);
    chk("state0 after raw", 32'(m0.o_State_2), 32'd0);
    drv(5'd2, 5'd3, 1, 1, 1, 5'd1, 0, 0);
    tick();
    drv(5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 0);
    tick();
    chk("stallcnt0 cont", 32'(m0.o_StallCount), 32'd4);
    chk("stallcnt1 cont", 32'(m1.o_StallCount), 32'd3);
    chk("stallcnt2 sat", 32'(m2.o_StallCount), 32'd3);
    chk("midstall ctrl0", 32'(c0), 32'(C_STL));
    chk("midstall state0", 32'(m0.o_State_2), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst stall0", 32'(m0.o_StallCount), 32'd0);
    chk("async rst stall1", 32'(m1.o_StallCount), 32'd0);
    chk("async rst state0", 32'(m0.o_State_2), 32'd0);
    chk("async rst ctrl0", 32'(c0), 32'(C_RUN));
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post rst ctrl0", 32'(c0), 32'(C_RUN));
    chk("post rst state0", 32'(m0.o_State_2), 32'd0);
    chk("post rst stall0", 32'(m0.o_StallCount), 32'd0);

    // Branch flush over an active hazard, then flush counting and saturation.
    reset_all();
    tick();
    drv(5'd2, 5'd3, 1, 1, 1, 5'd1, 0, 0);
    tick();
    drv(5'd1, 5'd5, 1, 1, 1, 5'd4, 0, 1);
    #1;
    chk("br ctrl0", 32'(c0), 32'(C_BR));
    tick();
    chk("br flushcnt0", 32'(m0.o_FlushCount), 32'd1);
    chk("br stallcnt0", 32'(m0.o_StallCount), 32'd0);
    chk("br state0", 32'(m0.o_State_2), 32'd2);
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0);
    #1;
    chk("jmp ctrl0", 32'(c0), 32'(C_JMP));
    tick(); tick(); tick();
    chk("jmp flushcnt0", 32'(m0.o_FlushCount), 32'd4);
    chk("jmp flushcnt2 sat", 32'(m2.o_FlushCount), 32'd3);
    chk("jmp state0", 32'(m0.o_State_2), 32'd2);
    drv(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0);
    tick();
    chk("run state0", 32'(m0.o_State_2), 32'd0);
    chk("run flushcnt0", 32'(m0.o_FlushCount), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
